// File: rtl/ahb_arbiter_if.sv
// Bus-control signals exchanged between the two-master AHB arbiter and the
// CPU master wrapper, address/data muxes and slaves.
interface ahb_arbiter_if;
  // Request/grant handshake: a master holds HBUSREQ_Mx high until it sees
  // HGRANT_Mx; grants, HMASTER and HMASTLOCK only ever change on an
  // HREADY=1 edge, so HREADY acts as the transfer-advance qualifier.
  logic       HBUSREQ_M1;
  logic       HBUSREQ_M2;
  logic       HLOCK_M1;
  logic       HLOCK_M2;
  logic       HREADY;
  logic       HGRANT_M1;
  logic       HGRANT_M2;
  logic [3:0] HMASTER;
  logic       HMASTLOCK;

  // master: the arbiter itself; slave: the wrapper/mux side
  modport master (
    input  HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HREADY,
    output HGRANT_M1, HGRANT_M2, HMASTER, HMASTLOCK
  );
  modport slave (
    output HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HREADY,
    input  HGRANT_M1, HGRANT_M2, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter: fixed-priority or round-robin, locked transfers,
// and a hold-limit counter so neither master starves the other.
module ahb_arbiter #(
  parameter bit RR_MODE  = 1'b0,
  parameter int MAX_HOLD = 4,
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  ahb_arbiter_if.master bus,
  output logic [1:0]    dbg_state_o,
  output logic [HW-1:0] dbg_hold_cnt_o
);

  // Encoding doubles as the HMASTER id of the owner
  typedef enum logic [1:0] {
    ST_NONE   = 2'd0,
    ST_OWN_M1 = 2'd1,
    ST_OWN_M2 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          last_grant_q, last_grant_d;  // 1 = M2 was granted last
  logic [3:0]    hmaster_q, hmaster_d;
  logic          hmastlock_q, hmastlock_d;

  logic owner_req, owner_hlock, other_req, hold_full;
  state_e other_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_NONE;
      hold_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      hmaster_q    <= 4'd0;
      hmastlock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_grant_q <= last_grant_d;
      hmaster_q    <= hmaster_d;
      hmastlock_q  <= hmastlock_d;
    end
  end

  always_comb begin
    owner_req   = 1'b0;
    owner_hlock = 1'b0;
    other_req   = 1'b0;
    other_owner = ST_OWN_M1;
    case (state_q)
      ST_OWN_M1: begin
        owner_req   = bus.HBUSREQ_M1;
        owner_hlock = bus.HLOCK_M1;
        other_req   = bus.HBUSREQ_M2;
        other_owner = ST_OWN_M2;
      end
      ST_OWN_M2: begin
        owner_req   = bus.HBUSREQ_M2;
        owner_hlock = bus.HLOCK_M2;
        other_req   = bus.HBUSREQ_M1;
        other_owner = ST_OWN_M1;
      end
      default: ;
    endcase
    hold_full = (hold_cnt_q == HW'(MAX_HOLD));
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_grant_d = last_grant_q;
    hmaster_d    = hmaster_q;
    hmastlock_d  = hmastlock_q;
    if (bus.HREADY) begin
      if (owner_req && owner_hlock) begin
        state_d = state_q;
      end else if (!bus.HBUSREQ_M1 && !bus.HBUSREQ_M2) begin
        state_d = ST_NONE;
      end else if (bus.HBUSREQ_M1 != bus.HBUSREQ_M2) begin
        state_d = bus.HBUSREQ_M1 ? ST_OWN_M1 : ST_OWN_M2;
      end else if (state_q == ST_NONE) begin
        state_d = (RR_MODE && !last_grant_q) ? ST_OWN_M2 : ST_OWN_M1;
      end else if (RR_MODE) begin
        state_d = hold_full ? other_owner : state_q;
      end else if (state_q == ST_OWN_M1) begin
        state_d = hold_full ? ST_OWN_M2 : ST_OWN_M1;
      end else begin
        state_d = ST_OWN_M1;
      end

      if (state_d != state_q) begin
        hold_cnt_d = '0;
      end else if (!other_req) begin
        hold_cnt_d = '0;
      end else if (!hold_full) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end

      if (state_d != state_q && state_d != ST_NONE) begin
        last_grant_d = (state_d == ST_OWN_M2);
      end

      // Address-phase owner is whoever held the grant before this edge
      hmaster_d   = {2'b00, state_q};
      hmastlock_d = (state_q != ST_NONE) && owner_hlock;
    end
  end

  assign bus.HGRANT_M1  = (state_q == ST_OWN_M1);
  assign bus.HGRANT_M2  = (state_q == ST_OWN_M2);
  assign bus.HMASTER    = hmaster_q;
  assign bus.HMASTLOCK  = hmastlock_q;
  assign dbg_state_o    = state_q;
  assign dbg_hold_cnt_o = hold_cnt_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: one fixed-priority and one round-robin instance
// driven with identical stimulus, checked against hand-derived expectations.
module tb_ahb_arbiter;
  localparam int W = 7;  // {HGRANT_M1, HGRANT_M2, HMASTER[3:0], HMASTLOCK}

  logic clk, rst;
  logic req1, req2, lock1, lock2, rdy;
  int   total, bad;
  logic [W-1:0] exp_q[$];

  ahb_arbiter_if fix_if ();
  ahb_arbiter_if rr_if ();
  logic [1:0] fix_state, rr_state;
  logic [2:0] fix_hold, rr_hold;

  assign fix_if.HBUSREQ_M1 = req1;
  assign fix_if.HBUSREQ_M2 = req2;
  assign fix_if.HLOCK_M1   = lock1;
  assign fix_if.HLOCK_M2   = lock2;
  assign fix_if.HREADY     = rdy;
  assign rr_if.HBUSREQ_M1  = req1;
  assign rr_if.HBUSREQ_M2  = req2;
  assign rr_if.HLOCK_M1    = lock1;
  assign rr_if.HLOCK_M2    = lock2;
  assign rr_if.HREADY      = rdy;

  ahb_arbiter #(.RR_MODE(1'b0), .MAX_HOLD(4)) u_fix (
    .clk(clk), .rst(rst), .bus(fix_if.master),
    .dbg_state_o(fix_state), .dbg_hold_cnt_o(fix_hold)
  );
  ahb_arbiter #(.RR_MODE(1'b1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst(rst), .bus(rr_if.master),
    .dbg_state_o(rr_state), .dbg_hold_cnt_o(rr_hold)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pk(input logic g1, input logic g2,
                                      input int hm, input logic lk);
    pk = {g1, g2, 4'(hm), lk};
  endfunction

  function automatic logic [W-1:0] obs(input int sel);
    if (sel == 0) obs = {fix_if.HGRANT_M1, fix_if.HGRANT_M2, fix_if.HMASTER, fix_if.HMASTLOCK};
    else          obs = {rr_if.HGRANT_M1, rr_if.HGRANT_M2, rr_if.HMASTER, rr_if.HMASTLOCK};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r1, input logic r2, input logic l1,
                       input logic l2, input logic rd);
    req1 = r1; req2 = r2; lock1 = l1; lock2 = l2; rdy = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(0, 0, 0, 0, 1);
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      rst = (i == 0);
      case (i)
        0: begin drive(1, 1, 0, 0, 1); e = pk(0, 0, 0, 0); end
        1: begin drive(0, 0, 0, 0, 1); e = pk(0, 0, 0, 0); end
        2: begin drive(0, 1, 0, 0, 1); e = pk(0, 1, 0, 0); end
        default: begin drive(0, 1, 0, 0, 1); e = pk(0, 1, 2, 0); end
      endcase
      exp_q.push_back(e);
      exp_q.push_back(e);
      step();
      for (int s = 0; s < 2; s++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(s) !== e) begin
          bad++;
          $display("FAIL reset_single[%0d] dut=%0d got=%b exp=%b", i, s, obs(s), e);
        end
      end
    end
  endtask

  task automatic test_fixed_preempt();
    logic [W-1:0] e;
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      drive(i >= 2, 1, 0, 0, 1);
      if (i == 0)      e = pk(0, 1, 0, 0);
      else if (i == 1) e = pk(0, 1, 2, 0);
      else if (i == 2) e = pk(1, 0, 2, 0);
      else if (i <= 6) e = pk(1, 0, 1, 0);
      else if (i == 7) e = pk(0, 1, 1, 0);
      else             e = pk(1, 0, 2, 0);
      exp_q.push_back(e);
      step();
      e = exp_q.pop_front();
      total++;
      if (obs(0) !== e) begin
        bad++;
        $display("FAIL fixed_preempt[%0d] got=%b exp=%b", i, obs(0), e);
      end
    end
  endtask

  task automatic test_rr_hold();
    logic [W-1:0] e;
    logic own_m1;
    int prev;
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      drive(1, 1, 0, 0, 1);
      own_m1 = ((i / 5) % 2 == 0);
      if (i == 0) prev = 0;
      else prev = (((i - 1) / 5) % 2 == 0) ? 1 : 2;
      exp_q.push_back(pk(own_m1, !own_m1, prev, 0));
      step();
      e = exp_q.pop_front();
      total++;
      if (obs(1) !== e) begin
        bad++;
        $display("FAIL rr_hold[%0d] got=%b exp=%b", i, obs(1), e);
      end
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] e;
    reset_dut();
    for (int i = 0; i < 23; i++) begin
      if (i == 0)       begin drive(1, 0, 1, 0, 1); e = pk(1, 0, 0, 0); end
      else if (i <= 20) begin drive(1, 1, 1, 0, 1); e = pk(1, 0, 1, 1); end
      else if (i == 21) begin drive(1, 1, 0, 0, 1); e = pk(0, 1, 1, 0); end
      else              begin drive(0, 1, 0, 0, 1); e = pk(0, 1, 2, 0); end
      exp_q.push_back(e);
      step();
      e = exp_q.pop_front();
      total++;
      if (obs(0) !== e) begin
        bad++;
        $display("FAIL lock[%0d] got=%b exp=%b", i, obs(0), e);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [W-1:0] e;
    logic [2:0] eh;
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      begin drive(1, 0, 0, 0, 1); e = pk(1, 0, 0, 0); eh = 3'd0; end
      else if (i <= 4) begin drive(1, 1, 0, 0, 1); e = pk(1, 0, 1, 0); eh = 3'(i); end
      else if (i <= 7) begin drive(1, 1, 0, 0, 0); e = pk(1, 0, 1, 0); eh = 3'd4; end
      else if (i == 8) begin drive(1, 1, 0, 0, 1); e = pk(0, 1, 1, 0); eh = 3'd0; end
      else             begin drive(1, 1, 0, 0, 1); e = pk(1, 0, 2, 0); eh = 3'd0; end
      exp_q.push_back(e);
      step();
      e = exp_q.pop_front();
      total++;
      if (obs(0) !== e) begin
        bad++;
        $display("FAIL wait_states[%0d] got=%b exp=%b", i, obs(0), e);
      end
      total++;
      if (fix_hold !== eh) begin
        bad++;
        $display("FAIL wait_hold[%0d] got=%0d exp=%0d", i, fix_hold, eh);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    reset_dut();
    drive(0, 1, 0, 1, 1);
    exp_q.push_back(pk(0, 1, 0, 0));
    step();
    e = exp_q.pop_front();
    total++;
    if (obs(0) !== e) begin
      bad++;
      $display("FAIL async_pre0 got=%b exp=%b", obs(0), e);
    end
    exp_q.push_back(pk(0, 1, 2, 1));
    step();
    e = exp_q.pop_front();
    total++;
    if (obs(0) !== e) begin
      bad++;
      $display("FAIL async_pre1 got=%b exp=%b", obs(0), e);
    end
    // assert reset between edges and look before the next rising edge
    #3;
    rst = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs(0) !== e) begin
      bad++;
      $display("FAIL async_mid got=%b exp=%b", obs(0), e);
    end
    step();
    rst = 1'b0;
    drive(1, 1, 0, 0, 1);
    exp_q.push_back(pk(1, 0, 0, 0));
    exp_q.push_back(pk(1, 0, 0, 0));
    step();
    for (int s = 0; s < 2; s++) begin
      e = exp_q.pop_front();
      total++;
      if (obs(s) !== e) begin
        bad++;
        $display("FAIL async_restart dut=%0d got=%b exp=%b", s, obs(s), e);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0, 1);
    #2;
    test_reset();
    test_fixed_preempt();
    test_rr_hold();
    test_lock();
    test_wait_states();
    test_async_reset();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
